// File: rtl/move_scheduler.sv
// move_scheduler: turns four raw direction buttons into at most one bounded
// grid step per video frame for the player sprite position.
// Each button is synchronised, debounced and latched as a pending request.
// On frame_tick the FSM grants the highest-priority request
// (up > down > left > right) and applies the step two cycles later.
module move_scheduler #(
  parameter int DEB_CYCLES    = 16,
  parameter int REPEAT_FRAMES = 8,
  parameter int GRID_W        = 40,
  parameter int GRID_H        = 30,
  parameter int START_X       = 20,
  parameter int START_Y       = 15
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       frame_tick,
  output logic [5:0] pos_x,
  output logic [4:0] pos_y,
  output logic [1:0] dir,
  output logic       move_valid,
  output logic       blocked
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES);
  localparam logic [5:0]    X_MAX    = 6'(GRID_W - 1);
  localparam logic [4:0]    Y_MAX    = 5'(GRID_H - 1);
  localparam logic [5:0]    X_RST    = 6'(START_X);
  localparam logic [4:0]    Y_RST    = 5'(START_Y);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARB    = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  // Bit order everywhere: 0=up, 1=down, 2=left, 3=right (matches dir encoding).
  logic [3:0] w_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_pend;
  logic [3:0] w_grant_clr;
  logic [1:0] w_grant_dir;
  logic       w_grant_any;
  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_gdir;
  logic [5:0] r_pos_x;
  logic [4:0] r_pos_y;
  logic [1:0] r_dir;
  logic       r_move_valid;
  logic       r_blocked;
  logic [5:0] w_step_x;
  logic [4:0] w_step_y;
  logic       w_step_blk;

  assign w_raw = {right, left, down, up};

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic [DW-1:0] r_deb_cnt;
      logic          r_deb;
      logic [RW-1:0] r_rep_cnt;
      logic          r_pend;
      logic          w_rise;
      logic          w_rep_set;

      // Debounced level is about to go 0->1 in this cycle.
      assign w_rise    = !r_deb && r_sync2[gi] && (r_deb_cnt == DEB_LAST);
      // Repeat counter sat at REPEAT_FRAMES for one cycle: raise a new request.
      assign w_rep_set = r_deb && (r_rep_cnt == REP_LAST);
      assign w_pend[gi] = r_pend;

      // Debounce: accept a new level only after DEB_CYCLES consecutive differing cycles.
      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          r_deb_cnt <= '0;
          r_deb     <= 1'b0;
        end else if (r_sync2[gi] == r_deb) begin
          r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          r_deb     <= ~r_deb;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end

      // Auto-repeat: count frames while held; a tick landing on the wrap cycle still counts.
      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          r_rep_cnt <= '0;
        end else if (!r_deb) begin
          r_rep_cnt <= '0;
        end else if (r_rep_cnt == REP_LAST) begin
          r_rep_cnt <= frame_tick ? RW'(1) : '0;
        end else if (frame_tick) begin
          r_rep_cnt <= r_rep_cnt + 1'b1;
        end
      end

      // Pending request: set on press or repeat, cleared by its own grant; set wins.
      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          r_pend <= 1'b0;
        end else if (w_rise || w_rep_set) begin
          r_pend <= 1'b1;
        end else if (w_grant_clr[gi]) begin
          r_pend <= 1'b0;
        end
      end
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus fixed-priority arbitration in the ARB cycle.
  always_comb begin
    w_state_next = r_state;
    w_grant_any  = |w_pend;
    w_grant_dir  = 2'd0;
    w_grant_clr  = 4'b0000;
    if (w_pend[0]) begin
      w_grant_dir = 2'd0;
    end else if (w_pend[1]) begin
      w_grant_dir = 2'd1;
    end else if (w_pend[2]) begin
      w_grant_dir = 2'd2;
    end else begin
      w_grant_dir = 2'd3;
    end
    case (r_state)
      S_IDLE: begin
        if (frame_tick) begin
          w_state_next = S_ARB;
        end
      end
      S_ARB: begin
        if (w_grant_any) begin
          w_grant_clr  = 4'b0001 << w_grant_dir;
          w_state_next = S_UPDATE;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_UPDATE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Hold the granted direction from ARB into UPDATE.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_gdir <= 2'd0;
    end else if (r_state == S_ARB && w_grant_any) begin
      r_gdir <= w_grant_dir;
    end
  end

  // Bounded step: a move that would leave the grid holds position and flags blocked.
  always_comb begin
    w_step_x   = r_pos_x;
    w_step_y   = r_pos_y;
    w_step_blk = 1'b0;
    case (r_gdir)
      2'd0: begin
        if (r_pos_y == 5'd0) w_step_blk = 1'b1;
        else                 w_step_y   = r_pos_y - 5'd1;
      end
      2'd1: begin
        if (r_pos_y >= Y_MAX) w_step_blk = 1'b1;
        else                  w_step_y   = r_pos_y + 5'd1;
      end
      2'd2: begin
        if (r_pos_x == 6'd0) w_step_blk = 1'b1;
        else                 w_step_x   = r_pos_x - 6'd1;
      end
      default: begin
        if (r_pos_x >= X_MAX) w_step_blk = 1'b1;
        else                  w_step_x   = r_pos_x + 6'd1;
      end
    endcase
  end

  // Position, direction and one-cycle result pulses, updated in the UPDATE cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pos_x      <= X_RST;
      r_pos_y      <= Y_RST;
      r_dir        <= 2'd0;
      r_move_valid <= 1'b0;
      r_blocked    <= 1'b0;
    end else begin
      r_move_valid <= 1'b0;
      r_blocked    <= 1'b0;
      if (r_state == S_UPDATE) begin
        r_pos_x      <= w_step_x;
        r_pos_y      <= w_step_y;
        r_dir        <= r_gdir;
        r_move_valid <= !w_step_blk;
        r_blocked    <= w_step_blk;
      end
    end
  end

  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign dir        = r_dir;
  assign move_valid = r_move_valid;
  assign blocked    = r_blocked;

endmodule
